// File: rtl/bj_pkg.sv
// bj_pkg: shared card codes, hand geometry and dealer state encoding.
package bj_pkg;
    localparam logic [3:0] CARD_EMPTY = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_KING  = 4'd13;
    localparam int HAND_SLOTS = 9;
    localparam int BUST_LIMIT = 21;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAL,
        ST_DRAW,
        ST_SETTLE,
        ST_WAIT,
        ST_DONE
    } dealer_state_t;
    function automatic logic valid_card(input logic [3:0] code);
        return code >= CARD_ACE && code <= CARD_KING;
    endfunction
endpackage

// File: rtl/sm_if.sv
// SM_if: player hand slots handed to the card-value summing stage.
interface SM_if;
    import bj_pkg::*;
    logic [3:0] player_card_values [0:HAND_SLOTS-1];
    modport out (output player_card_values);
    modport in  (input  player_card_values);
endinterface

// File: rtl/card_lfsr.sv
// card_lfsr: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= SEED;
        else      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
endmodule

// File: rtl/player_hand_dealer.sv
// player_hand_dealer: deals and draws the player's hand, detects bust from the
// summing stage's registered total.
module player_hand_dealer
    import bj_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter bit          EXT_SRC   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic [3:0] ext_card,
    input  logic       ext_card_valid,
    input  logic [5:0] total_players_value,
    SM_if.out          card_if,
    output logic [3:0] card_count,
    output logic       ready,
    output logic       done,
    output logic       bust
);
    dealer_state_t state, next;
    logic [15:0] lfsr;
    logic [3:0]  slots [0:HAND_SLOTS-1];
    logic [3:0]  card;
    logic        accept, over, settled, unused_lfsr;

    card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .state(lfsr));

    assign unused_lfsr = ^lfsr[15:4];
    assign card   = EXT_SRC ? ext_card : lfsr[3:0];
    assign accept = (state == ST_DEAL || state == ST_DRAW) && valid_card(card) && (!EXT_SRC || ext_card_valid);
    assign over   = total_players_value > 6'(BUST_LIMIT);
    assign ready  = state == ST_WAIT;
    assign done   = state == ST_DONE;

    for (genvar i = 0; i < HAND_SLOTS; i++) begin : g_slot
        assign card_if.player_card_values[i] = slots[i];
    end

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:   if (start) next = ST_DEAL;
            ST_DEAL:   if (accept && card_count == 4'd1) next = ST_SETTLE;
            ST_DRAW:   if (accept) next = ST_SETTLE;
            ST_SETTLE: if (settled) next = (over || card_count == 4'(HAND_SLOTS)) ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (stand) next = ST_DONE;
                       else if (hit) next = ST_DRAW;
            ST_DONE:   if (start) next = ST_DEAL;
            default:   next = ST_IDLE;
        endcase
    end

    // settled marks the second SETTLE cycle, when the registered total reflects the newest card
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= ST_IDLE;
            slots      <= '{default: CARD_EMPTY};
            card_count <= '0;
            bust       <= 1'b0;
            settled    <= 1'b0;
        end else begin
            state   <= next;
            settled <= state == ST_SETTLE && !settled;
            if (state == ST_DONE && start) begin
                slots      <= '{default: CARD_EMPTY};
                card_count <= '0;
                bust       <= 1'b0;
            end
            if (accept) begin
                slots[card_count] <= card;
                card_count        <= card_count + 4'd1;
            end
            if (state == ST_SETTLE && settled && over) bust <= 1'b1;
        end
endmodule

// File: tb/tb_player_hand_dealer.sv
// tb_player_hand_dealer: directed vectors for external-card and LFSR dealers.
module tb_player_hand_dealer;
    logic       clk = 1'b0;
    logic       rst_e, start_e, hit_e, stand_e, ext_valid;
    logic [3:0] ext_card;
    logic [5:0] total_e, total_l;
    logic [3:0] count_e, count_l;
    logic       ready_e, done_e, bust_e;
    logic       rst_l, start_l, hit_l;
    logic       ready_l, done_l, bust_l;
    int         n_vec = 0, n_err = 0;

    SM_if card_e ();
    SM_if card_l ();

    always #5 clk = ~clk;

    player_hand_dealer #(.LFSR_SEED(16'hACE1), .EXT_SRC(1'b1)) dut_ext (
        .clk(clk), .rst(rst_e), .start(start_e), .hit(hit_e), .stand(stand_e),
        .ext_card(ext_card), .ext_card_valid(ext_valid), .total_players_value(total_e),
        .card_if(card_e), .card_count(count_e), .ready(ready_e), .done(done_e), .bust(bust_e)
    );

    player_hand_dealer #(.LFSR_SEED(16'hACE1), .EXT_SRC(1'b0)) dut_lfsr (
        .clk(clk), .rst(rst_l), .start(start_l), .hit(hit_l), .stand(1'b0),
        .ext_card(4'd0), .ext_card_valid(1'b0), .total_players_value(total_l),
        .card_if(card_l), .card_count(count_l), .ready(ready_l), .done(done_l), .bust(bust_l)
    );

    function automatic logic [5:0] hand_sum(input logic [3:0] v [0:8]);
        logic [5:0] s = '0;
        for (int i = 0; i < 9; i++) s += 6'(v[i]);
        return s;
    endfunction

    // reference for the first card dealt after reset: first valid nibble after the seed
    function automatic int first_lfsr_card(input logic [15:0] seed);
        logic [15:0] s = seed;
        for (int i = 0; i < 64; i++) begin
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
            if (s[3:0] >= 4'd1 && s[3:0] <= 4'd13) return int'(s[3:0]);
        end
        return -1;
    endfunction

    // summing stage stand-in: one-cycle registered total of the slots
    always @(posedge clk) begin
        total_e <= hand_sum(card_e.player_card_values);
        total_l <= hand_sum(card_l.player_card_values);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic deal(input logic [3:0] a, input logic [3:0] b);
        start_e = 1'b1; ext_card = a; ext_valid = 1'b1;
        tick();
        start_e = 1'b0;
        tick();
        ext_card = b;
        tick();
        ext_valid = 1'b0;
        tick();
        chk("deal_ready_early", ready_e, 0);
        tick();
        chk("deal_ready", ready_e, 1);
        chk("deal_slot0", card_e.player_card_values[0], a);
        chk("deal_slot1", card_e.player_card_values[1], b);
        chk("deal_count", count_e, 2);
    endtask

    task automatic hit_card(input logic [3:0] c);
        hit_e = 1'b1; ext_card = c; ext_valid = 1'b1;
        tick();
        hit_e = 1'b0;
        tick();
        ext_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int exp_first;
        rst_e = 1'b0; rst_l = 1'b0;
        start_e = 1'b0; hit_e = 1'b0; stand_e = 1'b0; ext_valid = 1'b0; ext_card = 4'd0;
        start_l = 1'b0; hit_l = 1'b0;
        repeat (2) tick();
        chk("rst_count", count_e, 0);
        chk("rst_ready", ready_e, 0);
        chk("rst_done", done_e, 0);
        chk("rst_bust", bust_e, 0);
        chk("rst_slot0", card_e.player_card_values[0], 0);
        rst_e = 1'b1;
        tick();

        deal(4'd10, 4'd7);
        chk("deal_slot2_empty", card_e.player_card_values[2], 0);
        chk("sum_17", total_e, 17);

        hit_e = 1'b1; ext_card = 4'd5; ext_valid = 1'b1;
        tick();
        hit_e = 1'b0;
        tick();
        ext_valid = 1'b0;
        tick();
        chk("bust_done_early", done_e, 0);
        tick();
        chk("bust_done", done_e, 1);
        chk("bust_flag", bust_e, 1);
        chk("bust_ready", ready_e, 0);
        chk("bust_slot2", card_e.player_card_values[2], 5);
        chk("bust_count", count_e, 3);

        start_e = 1'b1; ext_card = 4'd2; ext_valid = 1'b1;
        tick();
        start_e = 1'b0;
        chk("restart_slot2_clr", card_e.player_card_values[2], 0);
        chk("restart_count_clr", count_e, 0);
        chk("restart_bust_clr", bust_e, 0);
        chk("restart_done_clr", done_e, 0);
        tick();
        ext_card = 4'd3;
        tick();
        ext_valid = 1'b0;
        tick();
        tick();
        chk("r3_ready", ready_e, 1);
        stand_e = 1'b1; hit_e = 1'b1;
        tick();
        stand_e = 1'b0; hit_e = 1'b0;
        chk("stand_done", done_e, 1);
        chk("stand_bust", bust_e, 0);
        ext_card = 4'd9; ext_valid = 1'b1;
        repeat (3) tick();
        ext_valid = 1'b0;
        chk("stand_count", count_e, 2);
        chk("stand_no_third", card_e.player_card_values[2], 0);

        deal(4'd2, 4'd3);
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
        chk("start_ignored_ready", ready_e, 1);
        chk("start_ignored_count", count_e, 2);
        hit_e = 1'b1; ext_card = 4'd14; ext_valid = 1'b1;
        tick();
        hit_e = 1'b0;
        tick();
        ext_card = 4'd0;
        tick();
        chk("retry_hold", count_e, 2);
        ext_card = 4'd4;
        tick();
        ext_valid = 1'b0;
        chk("retry_slot2", card_e.player_card_values[2], 4);
        chk("retry_count", count_e, 3);
        tick();
        chk("retry_ready_early", ready_e, 0);
        tick();
        chk("retry_ready", ready_e, 1);
        stand_e = 1'b1;
        tick();
        stand_e = 1'b0;

        deal(4'd2, 4'd2);
        for (int k = 2; k < 9; k++) begin
            hit_card(4'd2);
            chk("nine_count", count_e, k + 1);
            if (k < 8) chk("nine_ready", ready_e, 1);
        end
        chk("nine_done", done_e, 1);
        chk("nine_bust", bust_e, 0);
        chk("nine_slot8", card_e.player_card_values[8], 2);
        hit_card(4'd2);
        chk("full_hit_count", count_e, 9);
        chk("full_hit_done", done_e, 1);

        rst_l = 1'b1;
        tick();
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        for (int i = 0; i < 60 && !(ready_l || done_l); i++) tick();
        chk("lfsr_round_end", int'(ready_l | done_l), 1);
        if (ready_l) begin
            hit_l = 1'b1;
            tick();
            hit_l = 1'b0;
        end
        rst_l = 1'b0;
        #1;
        chk("mid_rst_count", count_l, 0);
        chk("mid_rst_ready", ready_l, 0);
        chk("mid_rst_done", done_l, 0);
        chk("mid_rst_bust", bust_l, 0);
        for (int i = 0; i < 9; i++) chk("mid_rst_slot", card_l.player_card_values[i], 0);
        tick();
        rst_l = 1'b1; start_l = 1'b1;
        tick();
        start_l = 1'b0;
        exp_first = first_lfsr_card(16'hACE1);
        for (int i = 0; i < 40 && count_l == 4'd0; i++) tick();
        chk("lfsr_first_card", card_l.player_card_values[0], exp_first);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
